dce_sf_maint_ctrl: RTL
======================

// Module: dce_sf_maint_ctrl
// PURPOSE
//  Sequences snoop-filter maintenance operations requested through the DCEUSFMCR/DCEUSFMAR CSRs.
//  Supported operations: init-all, flush-all, flush-by-index/way and flush-by-address.
//  Issues one maintenance request per handshake to the tag-filter directory and drives DCEUSFMAR_MntOpActv.
//  Holds off flush-by-address while the line address collides with a live ATT entry.
//  Sits between csr_array and dirm inside dce_unit.
// PARAMETERS
//  N_SETS  1024 snoop-filter sets (power of 2, >=2)
//  N_WAYS  8    snoop-filter ways (power of 2, >=1)
//  W_ADDR  48   physical address width (wSfiAddress)
//  W_SET   10   set-index width, = clog2(N_SETS)
//  W_WAY   3    way-index width, = max(1, clog2(N_WAYS))
// PORTS
//  clk               in  1       clock
//  resetn            in  1       synchronous reset, active-low
//  csr_op_valid      in  1       one-cycle pulse: MntOp CSR written
//  csr_op_code       in  4       0=init-all 4=flush-idx/way 5=flush-addr 6=flush-all; others illegal
//  csr_op_index      in  W_SET   set for code 4
//  csr_op_way        in  W_WAY   way for code 4
//  csr_op_addr       in  W_ADDR  address for code 5
//  att_addr_hit      in  1       ATT compare of maint_req_address hit (combinational from atm)
//  maint_req_valid   out 1       request to dirm
//  maint_req_ready   in  1       dirm accepts request
//  maint_req_op      out 2       0=init 1=flush-idx 2=flush-addr
//  maint_req_set     out W_SET   set index
//  maint_req_way     out W_WAY   way index
//  maint_req_address out W_ADDR  64B-aligned line address
//  mnt_op_actv       out 1       DCEUSFMAR_MntOpActv
//  mnt_op_done       out 1       one-cycle pulse, operation complete
//  mnt_op_err        out 1       one-cycle pulse, request rejected
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): all outputs 0, FSM=IDLE, set/way counters 0.
//    Applies mid-operation: outstanding request is dropped, no done pulse, no err pulse.
//  - FSM states: IDLE, SWEEP, SINGLE, ADDR_CHK, ISSUE_ADDR.
//  - IDLE, csr_op_valid at cycle N:
//    - code 0/6 -> SWEEP, set=0, way=0.
//    - code 4 -> SINGLE.
//    - code 5 -> ADDR_CHK; latch addr & ~'h3f into maint_req_address.
//    - mnt_op_actv=1 and maint_req_valid=1 (SWEEP/SINGLE) from cycle N+1.
//  - Rejected at cycle N, pulsing mnt_op_err at N+1 and staying IDLE:
//    - illegal code;
//    - code 4 with csr_op_index>=N_SETS or csr_op_way>=N_WAYS.
//  - csr_op_valid while mnt_op_actv=1: ignored, err pulse next cycle, current op unaffected.
//  - Handshake: transfer when valid&&ready. Once raised, valid stays high and payload stays stable until the transfer.
//  - SWEEP request sequencing:
//    - way increments per transfer; on wrap from N_WAYS-1 to 0, set increments.
//    - with ready held high, one transfer per cycle (N_SETS*N_WAYS cycles total).
//  - maint_req_op during SWEEP: 0 for code 0, 1 for code 6.
//  - SINGLE: one transfer of op=1 at the latched set/way.
//  - ADDR_CHK: maint_req_valid=0 while att_addr_hit=1 (any number of cycles). First cycle with hit=0 -> ISSUE_ADDR.
//  - ISSUE_ADDR: valid=1, op=2 until transfer. att_addr_hit is ignored after valid rises.
//  - Completion (final transfer at cycle M): at M+1, mnt_op_done=1, mnt_op_actv=0, valid=0, FSM=IDLE.
//    A new csr_op_valid at M+1 is accepted.
//  - Counters are W_SET/W_WAY wide. Final SWEEP transfer is detected at set=N_SETS-1 && way=N_WAYS-1, so the counters never overflow.
// TESTING
//  - Init sweep, N_SETS=4 N_WAYS=2, ready=1: op at cyc0 -> 8 transfers cyc1..8, (set,way) order (0,0)(0,1)(1,0)..(3,1); done at cyc9.
//  - Same sweep, ready toggling 1/0: 8 transfers, payload stable while stalled, done one cycle after 8th transfer.
//  - Flush-addr 0x12345 with att_addr_hit=1 for 3 cycles: valid low 3 cycles; then address=0x12340, op=2; one transfer; done.
//  - Illegal code 3 -> err pulse at N+1, actv stays 0. Code 4 index=N_SETS -> err pulse, no request issued.
//  - csr_op_valid mid-sweep -> err pulse; sweep still completes all N_SETS*N_WAYS transfers.
//  - resetn=0 mid-sweep at set=2 -> next cycle valid=0, actv=0, no done. New init restarts at (0,0).

Source files
------------

// File: rtl/dce_sf_maint_ctrl_if.sv
// Maintenance request channel from the snoop-filter maintenance sequencer to dirm,
// including the ATT address-compare result that gates flush-by-address.
interface dce_sf_maint_ctrl_if #(
  parameter int W_ADDR = 48,
  parameter int W_SET  = 10,
  parameter int W_WAY  = 3
);
  logic              maint_req_valid;
  logic              maint_req_ready;
  logic [1:0]        maint_req_op;
  logic [W_SET-1:0]  maint_req_set;
  logic [W_WAY-1:0]  maint_req_way;
  logic [W_ADDR-1:0] maint_req_address;
  logic              att_addr_hit;

  modport master (
    output maint_req_valid, maint_req_op, maint_req_set, maint_req_way, maint_req_address,
    input  maint_req_ready, att_addr_hit
  );

  modport slave (
    input  maint_req_valid, maint_req_op, maint_req_set, maint_req_way, maint_req_address,
    output maint_req_ready, att_addr_hit
  );
endinterface

// File: rtl/dce_sf_maint_ctrl.sv
// Snoop-filter maintenance sequencer: turns MntOp CSR writes into a stream of
// init/flush requests to the tag-filter directory and reports active/done/err.
module dce_sf_maint_ctrl #(
  parameter int N_SETS = 1024,
  parameter int N_WAYS = 8,
  parameter int W_ADDR = 48,
  parameter int W_SET  = 10,
  parameter int W_WAY  = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              csr_op_valid,
  input  logic [3:0]        csr_op_code,
  input  logic [W_SET-1:0]  csr_op_index,
  input  logic [W_WAY-1:0]  csr_op_way,
  input  logic [W_ADDR-1:0] csr_op_addr,
  dce_sf_maint_ctrl_if.master mreq,
  output logic              mnt_op_actv,
  output logic              mnt_op_done,
  output logic              mnt_op_err
);

  typedef enum logic [2:0] {IDLE, SWEEP, SINGLE, ADDR_CHK, ISSUE_ADDR} state_e;

  state_e            state_q, state_d;
  logic [W_SET-1:0]  set_q, set_d;
  logic [W_WAY-1:0]  way_q, way_d;
  logic [1:0]        op_q, op_d;
  logic [W_ADDR-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic req_valid;
  logic xfer;
  logic last_set, last_way;
  logic idx_ok;

  always_comb begin
    req_valid = (state_q == SWEEP) || (state_q == SINGLE) || (state_q == ISSUE_ADDR);
    xfer      = req_valid && mreq.maint_req_ready;
    last_set  = (set_q == W_SET'(N_SETS - 1));
    last_way  = (way_q == W_WAY'(N_WAYS - 1));
    idx_ok    = (32'(csr_op_index) < N_SETS) && (32'(csr_op_way) < N_WAYS);

    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    op_d    = op_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (csr_op_valid) begin
          case (csr_op_code)
            4'd0, 4'd6: begin
              state_d = SWEEP;
              set_d   = '0;
              way_d   = '0;
              op_d    = (csr_op_code == 4'd6) ? 2'd1 : 2'd0;
            end
            4'd4: begin
              if (idx_ok) begin
                state_d = SINGLE;
                set_d   = csr_op_index;
                way_d   = csr_op_way;
                op_d    = 2'd1;
              end else begin
                err_d = 1'b1;
              end
            end
            4'd5: begin
              state_d = ADDR_CHK;
              addr_d  = csr_op_addr & ~W_ADDR'(6'h3f);
              op_d    = 2'd2;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      SWEEP: begin
        if (xfer) begin
          // Terminal (set,way) is compared explicitly so the counters never wrap.
          if (last_set && last_way) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (last_way) begin
            way_d = '0;
            set_d = set_q + 1'b1;
          end else begin
            way_d = way_q + 1'b1;
          end
        end
      end
      SINGLE, ISSUE_ADDR: begin
        if (xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      ADDR_CHK: begin
        if (!mreq.att_addr_hit) state_d = ISSUE_ADDR;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && csr_op_valid) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      set_q   <= '0;
      way_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mreq.maint_req_valid   = req_valid;
  assign mreq.maint_req_op      = op_q;
  assign mreq.maint_req_set     = set_q;
  assign mreq.maint_req_way     = way_q;
  assign mreq.maint_req_address = addr_q;
  assign mnt_op_actv            = (state_q != IDLE);
  assign mnt_op_done            = done_q;
  assign mnt_op_err             = err_q;

endmodule
